fc_seq_ctrl: RTL and testbench
==============================

FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 8, signed input/weight element width.
REQ-002 Parameter ACC_WIDTH, 24, signed accumulator/bias/result width.
REQ-003 Parameter ARRAY_N, 16, elements per memory word (lanes).
REQ-004 Parameter ARRAY_M, 2, output channels computed in parallel (group size).
REQ-005 Parameter IN_CHANNEL, 96, input length; SHALL be a multiple of ARRAY_N, with elaboration error otherwise.
REQ-006 Parameter OUT_CHANNEL, 10, number of output channels.
REQ-007 Parameter ADDR_WIDTH, 10, memory address width.
REQ-008 Derived: BEATS=IN_CHANNEL/ARRAY_N; G=ceil(OUT_CHANNEL/ARRAY_M); IDX_W=max(1,clog2(OUT_CHANNEL)).
REQ-009 clk  in  1  clock, all logic on rising edge.
REQ-010 reset_n  in  1  reset, synchronous, active-low.
REQ-011 start  in  1  begin a layer; honoured only in IDLE.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse, result valid.
REQ-014 inp_rd_req / inp_rd_addr  out  1 / ADDR_WIDTH  input RAM read.
REQ-015 inp_rd_data  in  DATA_WIDTH*ARRAY_N  input word, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-016 wgt_rd_req / wgt_rd_addr  out  1 / ADDR_WIDTH  weight RAM read.
REQ-017 wgt_rd_data  in  ARRAY_M*DATA_WIDTH*ARRAY_N  slice m = weights of channel g*ARRAY_M+m.
REQ-018 bias_rd_req / bias_rd_addr  out  1 / ADDR_WIDTH  bias RAM read.
REQ-019 bias_rd_data  in  ARRAY_M*ACC_WIDTH  signed bias, slice m = channel g*ARRAY_M+m.
REQ-020 result_idx / result_val  out  IDX_W / ACC_WIDTH  argmax channel index and its value.

Function
REQ-021 All RAMs: data valid the cycle after req is high; addresses held only while req is high.
REQ-022 States: IDLE, RUN, DRAIN, CMP, DONE.
REQ-023 IDLE->RUN when start=1; group g=0, beat b=0, accumulators cleared, running max invalidated.
REQ-024 RUN: each cycle inp_rd_req=wgt_rd_req=1, inp_rd_addr=b, wgt_rd_addr=g*BEATS+b; b increments; after b=BEATS-1 -> DRAIN.
REQ-025 Each returned beat: acc[m] += sum over k of inp[k]*wgt[m][k], signed, modulo 2^ACC_WIDTH (wrap, no saturation).
REQ-026 DRAIN: last beat accumulated; bias_rd_req=1, bias_rd_addr=g; -> CMP.
REQ-027 CMP: val[m]=acc[m]+bias[m] (wrap); for m ascending, channel c=g*ARRAY_M+m replaces running max iff c<OUT_CHANNEL and (max invalid or val[m] > max, strictly); ties keep lowest index.
REQ-028 CMP: clear acc; if g<G-1 then g++, b=0, -> RUN; else -> DONE.
REQ-029 DONE: done=1 for one cycle, result_idx/result_val updated; -> IDLE.
REQ-030 Latency: done high exactly G*(BEATS+2)+1 cycles after the edge sampling start (defaults: 41).
REQ-031 result_idx/result_val hold their values until the next DONE.
REQ-032 start while busy ignored; start in DONE ignored.
REQ-033 Padded lanes (c>=OUT_CHANNEL) are computed but never compared.

Reset
REQ-034 reset_n=0 at any edge: state IDLE, all req outputs 0, all addresses 0, busy 0, done 0, result_idx 0, result_val 0, accumulators 0.
REQ-035 Reset mid-operation aborts without a done pulse; next start runs a full layer.

Configuration
REQ-036 FC_RELU_EN defined: val[m] below 0 is replaced by 0 before compare and output; all-negative layer yields idx 0, val 0.
REQ-037 FC_RELU_EN undefined: raw signed val[m] compared and output.

Verification
REQ-038 Inputs all 1, weights all 1, bias 0 -> result_idx 0, result_val 96, done at cycle 41.
REQ-039 As REQ-038 but channel 7 weights 2 -> result_idx 7, result_val 192.
REQ-040 Inputs 1, weights -1, bias ch3 = +10, others 0 -> idx 3, val -86; with FC_RELU_EN -> idx 0, val 0.
REQ-041 ACC_WIDTH=16, inputs 127, weights 127, bias 0 -> val wraps to -24480 for every channel, idx 0.
REQ-042 OUT_CHANNEL=9, ARRAY_M=2, padded lane 9 weights 127, others 1 -> idx 0, val 96.
REQ-043 start pulse at cycle 10 of a run ignored; reset_n low at cycle 20 -> busy 0 next cycle, no done; restart completes with correct result.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl -- sequencer and datapath for one fully-connected layer with
// argmax output.
//
// The input vector (IN_CHANNEL signed elements) is streamed from the input RAM
// ARRAY_N lanes per beat. It is multiplied against ARRAY_M output channels at a
// time (one "group"), using weights fetched from the weight RAM. The per-channel
// accumulators then receive their bias, and the running maximum over all real
// output channels is updated. After the last group, done pulses for one cycle
// and result_idx/result_val present the winning channel and its value.
//
// Optional build macro:
//   FC_RELU_EN  when defined, negative biased sums are clamped to 0 before
//               they are compared and reported.
//
// Ports:
//   clk, reset_n             clock (rising edge), synchronous active-low reset
//   start                    begin a layer (honoured only in IDLE)
//   busy, done               busy outside IDLE; done is a one-cycle result strobe
//   inp_rd_req/addr/data     input RAM read port (1-cycle read latency)
//   wgt_rd_req/addr/data     weight RAM read port, ARRAY_M channel slices
//   bias_rd_req/addr/data    bias RAM read port, ARRAY_M signed biases
//   result_idx, result_val   argmax channel and its value, held until next done
module fc_seq_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int ARRAY_N     = 16,
  parameter int ARRAY_M     = 2,
  parameter int IN_CHANNEL  = 96,
  parameter int OUT_CHANNEL = 10,
  parameter int ADDR_WIDTH  = 10,
  localparam int IDX_W      = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  inp_rd_req,
  output logic [ADDR_WIDTH-1:0]                 inp_rd_addr,
  input  logic [DATA_WIDTH*ARRAY_N-1:0]         inp_rd_data,
  output logic                                  wgt_rd_req,
  output logic [ADDR_WIDTH-1:0]                 wgt_rd_addr,
  input  logic [ARRAY_M*DATA_WIDTH*ARRAY_N-1:0] wgt_rd_data,
  output logic                                  bias_rd_req,
  output logic [ADDR_WIDTH-1:0]                 bias_rd_addr,
  input  logic [ARRAY_M*ACC_WIDTH-1:0]          bias_rd_data,
  output logic [IDX_W-1:0]                      result_idx,
  output logic signed [ACC_WIDTH-1:0]           result_val
);

  localparam int BEATS = IN_CHANNEL / ARRAY_N;
  localparam int G     = (OUT_CHANNEL + ARRAY_M - 1) / ARRAY_M;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int LW    = DATA_WIDTH * ARRAY_N;

  if ((IN_CHANNEL % ARRAY_N) != 0) begin : g_chk_in_channel
    $error("fc_seq_ctrl: IN_CHANNEL must be a multiple of ARRAY_N");
  end

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CMP, DONE} state_t;

  state_t                       state_q;
  logic [BW-1:0]                b_q;
  logic [GW-1:0]                g_q;
  logic                         busy_q, done_q;
  logic                         inp_rd_req_q, wgt_rd_req_q, bias_rd_req_q;
  logic [ADDR_WIDTH-1:0]        inp_rd_addr_q, wgt_rd_addr_q, bias_rd_addr_q;
  logic [IDX_W-1:0]             result_idx_q;
  logic signed [ACC_WIDTH-1:0]  result_val_q;
  logic                         rd_vld_q;
  logic signed [ACC_WIDTH-1:0]  acc_q [ARRAY_M];
  logic                         max_vld_q, max_vld_d;
  logic signed [ACC_WIDTH-1:0]  max_val_q, max_val_d;
  logic [IDX_W-1:0]             max_idx_q, max_idx_d;
  logic signed [ACC_WIDTH-1:0]  cand;

  // Dot product of one beat; products are sign-extended (or truncated) to the
  // accumulator width so the running sum wraps modulo 2^ACC_WIDTH.
  function automatic logic signed [ACC_WIDTH-1:0] dot(input logic [LW-1:0] a,
                                                      input logic [LW-1:0] w);
    logic signed [ACC_WIDTH-1:0]              s;
    logic signed [2*DATA_WIDTH-1:0]           p;
    logic signed [2*DATA_WIDTH+ACC_WIDTH-1:0] wide;
    s = '0;
    for (int k = 0; k < ARRAY_N; k++) begin
      p    = signed'(a[k*DATA_WIDTH +: DATA_WIDTH]) * signed'(w[k*DATA_WIDTH +: DATA_WIDTH]);
      wide = {{ACC_WIDTH{p[2*DATA_WIDTH-1]}}, p};
      s    = s + wide[ACC_WIDTH-1:0];
    end
    return s;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] activate(input logic signed [ACC_WIDTH-1:0] v);
`ifdef FC_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Running-max update for the group in CMP. Lanes are visited in ascending
  // channel order with a strict compare, so ties keep the lowest index;
  // padded lanes beyond OUT_CHANNEL are skipped.
  always_comb begin
    max_vld_d = max_vld_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    cand      = '0;
    for (int m = 0; m < ARRAY_M; m++) begin
      cand = activate(acc_q[m] + signed'(bias_rd_data[m*ACC_WIDTH +: ACC_WIDTH]));
      if ((int'(g_q) * ARRAY_M + m < OUT_CHANNEL) && (!max_vld_d || cand > max_val_d)) begin
        max_vld_d = 1'b1;
        max_val_d = cand;
        max_idx_d = IDX_W'(int'(g_q) * ARRAY_M + m);
      end
    end
  end

  // Accumulate the beat whose read was issued last cycle; clear after CMP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vld_q <= 1'b0;
      for (int m = 0; m < ARRAY_M; m++) acc_q[m] <= '0;
    end else begin
      rd_vld_q <= inp_rd_req_q;
      for (int m = 0; m < ARRAY_M; m++) begin
        if (state_q == CMP)
          acc_q[m] <= '0;
        else if (rd_vld_q)
          acc_q[m] <= acc_q[m] + dot(inp_rd_data, wgt_rd_data[m*LW +: LW]);
      end
    end
  end

  // Control FSM; every output is registered for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      b_q            <= '0;
      g_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      inp_rd_req_q   <= 1'b0;
      wgt_rd_req_q   <= 1'b0;
      bias_rd_req_q  <= 1'b0;
      inp_rd_addr_q  <= '0;
      wgt_rd_addr_q  <= '0;
      bias_rd_addr_q <= '0;
      result_idx_q   <= '0;
      result_val_q   <= '0;
      max_vld_q      <= 1'b0;
      max_val_q      <= '0;
      max_idx_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= RUN;
            busy_q        <= 1'b1;
            b_q           <= '0;
            g_q           <= '0;
            max_vld_q     <= 1'b0;
            inp_rd_req_q  <= 1'b1;
            wgt_rd_req_q  <= 1'b1;
            inp_rd_addr_q <= '0;
            wgt_rd_addr_q <= '0;
          end
        end
        RUN: begin
          if (b_q == BW'(BEATS - 1)) begin
            state_q        <= DRAIN;
            inp_rd_req_q   <= 1'b0;
            wgt_rd_req_q   <= 1'b0;
            bias_rd_req_q  <= 1'b1;
            bias_rd_addr_q <= ADDR_WIDTH'(g_q);
          end else begin
            b_q           <= b_q + 1'b1;
            inp_rd_addr_q <= inp_rd_addr_q + 1'b1;
            wgt_rd_addr_q <= wgt_rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          bias_rd_req_q <= 1'b0;
          state_q       <= CMP;
        end
        CMP: begin
          max_vld_q <= max_vld_d;
          max_val_q <= max_val_d;
          max_idx_q <= max_idx_d;
          if (g_q != GW'(G - 1)) begin
            // Weight words are contiguous per group, so the next group starts
            // one past the last address of this one.
            state_q       <= RUN;
            g_q           <= g_q + 1'b1;
            b_q           <= '0;
            inp_rd_req_q  <= 1'b1;
            wgt_rd_req_q  <= 1'b1;
            inp_rd_addr_q <= '0;
            wgt_rd_addr_q <= wgt_rd_addr_q + 1'b1;
          end else begin
            state_q      <= DONE;
            done_q       <= 1'b1;
            result_idx_q <= max_idx_d;
            result_val_q <= max_val_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign inp_rd_req   = inp_rd_req_q;
  assign inp_rd_addr  = inp_rd_addr_q;
  assign wgt_rd_req   = wgt_rd_req_q;
  assign wgt_rd_addr  = wgt_rd_addr_q;
  assign bias_rd_req  = bias_rd_req_q;
  assign bias_rd_addr = bias_rd_addr_q;
  assign result_idx   = result_idx_q;
  assign result_val   = result_val_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Testbench for fc_seq_ctrl: two instances (default parameters, and a
// 16-bit-accumulator / 9-channel variant) share behavioural RAM models.
// Expected argmax results come from a reference model and are queued per DUT
// when a layer is started; a monitor pops and compares them on each done.
module tb_fc_seq_ctrl;
  localparam int DW = 8, N = 16, M = 2, IN = 96, BEATS = 6, NCH = 10, AW = 10;
  localparam int ACC1 = 24, ACC2 = 16, OUT1 = 10, OUT2 = 9;

  typedef struct {
    int     idx;
    longint val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start;
  logic busy1, done1, ir1, wr1, br1;
  logic busy2, done2, ir2, wr2, br2;
  logic [AW-1:0] ia1, wa1, ba1, ia2, wa2, ba2;
  logic [N*DW-1:0] id1, id2;
  logic [M*N*DW-1:0] wd1, wd2;
  logic [M*ACC1-1:0] bd1;
  logic [M*ACC2-1:0] bd2;
  logic [3:0] idx1, idx2;
  logic [ACC1-1:0] val1;
  logic [ACC2-1:0] val2;

  int inp_m [IN];
  int wgt_m [NCH][IN];
  int bias_m [NCH];
  exp_t q1[$], q2[$];
  exp_t last1, last2;
  int n_chk = 0, n_fail = 0;

  fc_seq_ctrl u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy1), .done(done1),
    .inp_rd_req(ir1), .inp_rd_addr(ia1), .inp_rd_data(id1),
    .wgt_rd_req(wr1), .wgt_rd_addr(wa1), .wgt_rd_data(wd1),
    .bias_rd_req(br1), .bias_rd_addr(ba1), .bias_rd_data(bd1),
    .result_idx(idx1), .result_val(val1)
  );

  fc_seq_ctrl #(.ACC_WIDTH(ACC2), .OUT_CHANNEL(OUT2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy2), .done(done2),
    .inp_rd_req(ir2), .inp_rd_addr(ia2), .inp_rd_data(id2),
    .wgt_rd_req(wr2), .wgt_rd_addr(wa2), .wgt_rd_data(wd2),
    .bias_rd_req(br2), .bias_rd_addr(ba2), .bias_rd_data(bd2),
    .result_idx(idx2), .result_val(val2)
  );

  function automatic logic [N*DW-1:0] inp_word(input logic [AW-1:0] a);
    logic [N*DW-1:0] w;
    int t;
    w = '0;
    for (int k = 0; k < N; k++) begin
      t = inp_m[(int'(a) * N + k) % IN];
      w[k*DW +: DW] = t[DW-1:0];
    end
    return w;
  endfunction

  function automatic logic [M*N*DW-1:0] wgt_word(input logic [AW-1:0] a);
    logic [M*N*DW-1:0] w;
    int g, b, c, t;
    w = '0;
    g = int'(a) / BEATS;
    b = int'(a) % BEATS;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < N; k++) begin
        c = g * M + m;
        t = (c < NCH) ? wgt_m[c][b*N + k] : 0;
        w[(m*N + k)*DW +: DW] = t[DW-1:0];
      end
    return w;
  endfunction

  function automatic logic [M*ACC1-1:0] bias_word(input logic [AW-1:0] a, input int accw);
    logic [M*ACC1-1:0] w;
    int c, v;
    w = '0;
    for (int m = 0; m < M; m++) begin
      c = int'(a) * M + m;
      v = (c < NCH) ? bias_m[c] : 0;
      for (int j = 0; j < accw; j++) w[m*accw + j] = v[j];
    end
    return w;
  endfunction

  // RAM models: one-cycle read latency, data undefined when not requested.
  logic [M*ACC1-1:0] bw2;
  always @(posedge clk) begin
    id1 <= ir1 ? inp_word(ia1) : 'x;
    wd1 <= wr1 ? wgt_word(wa1) : 'x;
    bd1 <= br1 ? bias_word(ba1, ACC1) : 'x;
    id2 <= ir2 ? inp_word(ia2) : 'x;
    wd2 <= wr2 ? wgt_word(wa2) : 'x;
    bw2 = bias_word(ba2, ACC2);
    bd2 <= br2 ? bw2[M*ACC2-1:0] : 'x;
  end

  // Reference: wrap each biased sum to accw bits, optional clamp, strict argmax.
  function automatic exp_t model(input int accw, input int nout);
    exp_t e;
    longint s;
    bit have;
    have = 0;
    e.idx = 0;
    e.val = 0;
    for (int c = 0; c < nout; c++) begin
      s = longint'(bias_m[c]);
      for (int i = 0; i < IN; i++) s += longint'(inp_m[i]) * longint'(wgt_m[c][i]);
      s = (s <<< (64 - accw)) >>> (64 - accw);
`ifdef FC_RELU_EN
      if (s < 0) s = 0;
`endif
      if (!have || s > e.val) begin
        have = 1;
        e.idx = c;
        e.val = s;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done1) begin
      check("dut1_pending", longint'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dut1_idx", longint'(idx1), longint'(e.idx));
        check("dut1_val", longint'(signed'(val1)), e.val);
        last1 = e;
      end
    end
    if (reset_n && done2) begin
      check("dut2_pending", longint'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("dut2_idx", longint'(idx2), longint'(e.idx));
        check("dut2_val", longint'(signed'(val2)), e.val);
        last2 = e;
      end
    end
  end

  task automatic set_all(input int iv, input int wv, input int bv);
    for (int i = 0; i < IN; i++) inp_m[i] = iv;
    for (int c = 0; c < NCH; c++) begin
      bias_m[c] = bv;
      for (int i = 0; i < IN; i++) wgt_m[c][i] = wv;
    end
  endtask

  task automatic set_chan(input int c, input int wv);
    for (int i = 0; i < IN; i++) wgt_m[c][i] = wv;
  endtask

  // Runs one layer on both DUTs. Latency counts clock edges from the edge that
  // samples start to the edge that samples done high. poke>0 pulses start at
  // that cycle of the run; poke_done holds start high during the DONE cycle.
  task automatic run_layer(input string tag, input int poke, input bit poke_done);
    int k;
    bit got;
    q1.push_back(model(ACC1, OUT1));
    q2.push_back(model(ACC2, OUT2));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    got = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      start = (k == poke) ? 1'b1 : 1'b0;
      if (done1) got = 1;
    end
    check({tag, "_latency"}, k, 41);
    check({tag, "_done2_aligned"}, done2, 1);
    start = poke_done;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done1, 0);
    check({tag, "_idle_busy"}, busy1, 0);
    repeat (4) @(negedge clk);
    check({tag, "_hold_idx"}, idx1, last1.idx);
    check({tag, "_hold_val"}, longint'(signed'(val1)), last1.val);
  endtask

  initial begin
    int nd;
    reset_n = 1'b0;
    start   = 1'b0;
    set_all(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_reqs", {ir1, wr1, br1}, 0);
    check("rst_addrs", {ia1, wa1, ba1}, 0);
    check("rst_idx", idx1, 0);
    check("rst_val", val1, 0);
    check("rst_busy2", busy2, 0);
    reset_n = 1'b1;

    set_all(1, 1, 0);
    run_layer("ones", 0, 0);
    set_chan(7, 2);
    run_layer("ch7x2", 0, 0);
    set_all(1, -1, 0);
    bias_m[3] = 10;
    run_layer("neg_bias3", 0, 0);
    set_all(127, 127, 0);
    run_layer("wrap", 0, 0);
    set_all(1, 1, 0);
    set_chan(9, 127);
    run_layer("pad9", 10, 1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < IN; i++) inp_m[i] = int'($urandom_range(255, 0)) - 128;
      for (int c = 0; c < NCH; c++) begin
        bias_m[c] = int'($urandom_range(4000, 0)) - 2000;
        for (int i = 0; i < IN; i++) wgt_m[c][i] = int'($urandom_range(255, 0)) - 128;
      end
      run_layer("random", 0, 0);
    end

    // Abort: ignored start at cycle 10, reset at cycle 20, no done afterwards.
    set_all(1, 1, 0);
    set_chan(5, 3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start   = (k == 10);
      reset_n = (k != 20);
      if (done1 || done2) nd++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", busy1, 0);
    check("abort_busy2", busy2, 0);
    check("abort_reqs", {ir1, wr1, br1}, 0);
    check("abort_idx", idx1, 0);
    check("abort_val", val1, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done1 || done2) nd++;
    end
    check("abort_no_done", nd, 0);
    run_layer("restart", 0, 0);

    repeat (3) @(negedge clk);
    check("queue1_empty", q1.size(), 0);
    check("queue2_empty", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
